// File: rtl/spi_frame_controller.sv
// SPI slave framing: packs received SPI bytes into words for an RX FIFO and
// unpacks words from a TX FIFO into bytes, MSB-first, one frame per cs_n low.
module spi_frame_controller #(
    parameter int DATA_WIDTH     = 32,
    parameter int SPI_DATA_WIDTH = 8,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                                              clk,
    input  logic                                              rst,
    input  logic                                              cs_n,
    input  logic                                              byte_strobe,
    input  logic [SPI_DATA_WIDTH-1:0]                         rx_byte,
    output logic [SPI_DATA_WIDTH-1:0]                         tx_byte,
    output logic [DATA_WIDTH-1:0]                             rx_word,
    output logic                                              rx_valid,
    input  logic                                              rx_ready,
    input  logic [DATA_WIDTH-1:0]                             tx_word,
    input  logic                                              tx_valid,
    output logic                                              tx_ready,
    output logic                                              frame_active,
    output logic [$clog2(DATA_WIDTH/SPI_DATA_WIDTH)-1:0]      byte_index,
    output logic                                              overrun,
    output logic                                              underrun,
    output logic                                              frame_error
);
    localparam int BYTES = DATA_WIDTH / SPI_DATA_WIDTH;
    localparam int IDX_W = $clog2(BYTES);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(BYTES - 1);

    typedef enum logic [1:0] {IDLE, LOAD, ACTIVE} state_t;
    state_t state;

    logic [DATA_WIDTH-1:0] tx_mem [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] rx_mem [FIFO_DEPTH];
    logic [AW:0]           tx_wr, tx_rd, rx_wr, rx_rd;
    logic [DATA_WIDTH-1:0] tx_shift, rx_asm, rx_next, tx_head;
    logic [IDX_W-1:0]      idx_next;
    logic tx_empty, tx_full, rx_empty, rx_full;
    logic byte_adv, word_done, tx_pop_req, tx_pop, tx_push, rx_pop, rx_push;

    assign tx_empty = (tx_wr == tx_rd);
    assign tx_full  = (tx_wr[AW] != tx_rd[AW]) && (tx_wr[AW-1:0] == tx_rd[AW-1:0]);
    assign rx_empty = (rx_wr == rx_rd);
    assign rx_full  = (rx_wr[AW] != rx_rd[AW]) && (rx_wr[AW-1:0] == rx_rd[AW-1:0]);

    assign byte_adv   = (state == ACTIVE) && byte_strobe;
    assign word_done  = byte_adv && (byte_index == LAST);
    assign idx_next   = byte_adv ? ((byte_index == LAST) ? '0 : byte_index + 1'b1) : byte_index;
    assign rx_next    = {rx_asm[DATA_WIDTH-SPI_DATA_WIDTH-1:0], rx_byte};

    // A full FIFO still accepts a push when it pops in the same cycle; an
    // empty FIFO forwards a same-cycle push straight to the popping side.
    assign tx_pop_req = ((state == LOAD) && !cs_n) || word_done;
    assign tx_push    = tx_valid && (!tx_full || tx_pop_req);
    assign tx_pop     = tx_pop_req && (!tx_empty || tx_push);
    assign tx_head    = tx_empty ? tx_word : tx_mem[tx_rd[AW-1:0]];
    assign rx_pop     = !rx_empty && rx_ready;
    assign rx_push    = word_done && (!rx_full || rx_pop);

    assign rx_valid     = !rx_empty;
    assign rx_word      = rx_empty ? '0 : rx_mem[rx_rd[AW-1:0]];
    assign tx_ready     = !tx_full;
    assign frame_active = (state != IDLE);

    always_comb begin
        tx_byte = '0;
        if (state != IDLE)
            tx_byte = tx_shift[DATA_WIDTH-1-SPI_DATA_WIDTH*int'(byte_index) -: SPI_DATA_WIDTH];
    end

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wr[AW-1:0]] <= tx_word;
        if (rx_push) rx_mem[rx_wr[AW-1:0]] <= rx_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            byte_index  <= '0;
            overrun     <= 1'b0;
            underrun    <= 1'b0;
            frame_error <= 1'b0;
            tx_wr       <= '0;
            tx_rd       <= '0;
            rx_wr       <= '0;
            rx_rd       <= '0;
        end else begin
            if (tx_push) tx_wr <= tx_wr + 1'b1;
            if (tx_pop)  tx_rd <= tx_rd + 1'b1;
            if (rx_push) rx_wr <= rx_wr + 1'b1;
            if (rx_pop)  rx_rd <= rx_rd + 1'b1;

            case (state)
                IDLE: begin
                    byte_index <= '0;
                    if (!cs_n) begin
                        state       <= LOAD;
                        overrun     <= 1'b0;
                        underrun    <= 1'b0;
                        frame_error <= 1'b0;
                    end
                end
                LOAD: begin
                    if (cs_n) begin
                        state <= IDLE;
                    end else begin
                        state    <= ACTIVE;
                        tx_shift <= tx_pop ? tx_head : '0;
                        if (!tx_pop) underrun <= 1'b1;
                    end
                end
                ACTIVE: begin
                    if (byte_strobe) rx_asm <= rx_next;
                    byte_index <= idx_next;
                    if (word_done) begin
                        tx_shift <= tx_pop ? tx_head : '0;
                        if (!tx_pop)  underrun <= 1'b1;
                        if (!rx_push) overrun  <= 1'b1;
                    end
                    // The strobe in this cycle counts before judging the frame end.
                    if (cs_n) begin
                        state      <= IDLE;
                        byte_index <= '0;
                        if (idx_next != '0) frame_error <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
